// File: rtl/idu_core.sv
// RV32I decode stage: combinational instruction decode into ALU/jump/memory/writeback
// controls and operands, plus a single registered valid toward the system controller.
module idu_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sys_ready,
  output logic                  o_sys_valid,
  input  logic [31:0]           i_ram_inst,
  output logic [4:0]            o_idu_ctr_alu_type,
  output logic [1:0]            o_idu_ctr_alu_rs1,
  output logic [1:0]            o_idu_ctr_alu_rs2,
  output logic [1:0]            o_idu_ctr_jmp_type,
  output logic                  o_idu_ctr_ram_wr_en,
  output logic [2:0]            o_idu_ctr_ram_byt,
  output logic                  o_idu_ctr_reg_wr_en,
  output logic [1:0]            o_idu_ctr_reg_wr_src,
  input  logic [DATA_WIDTH-1:0] i_gpr_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_gpr_rs2_data,
  output logic [4:0]            o_idu_gpr_rs1_id,
  output logic [4:0]            o_idu_gpr_rs2_id,
  output logic [4:0]            o_idu_gpr_rd_id,
  input  logic [DATA_WIDTH-1:0] i_ifu_pc,
  output logic [DATA_WIDTH-1:0] o_idu_rs1_data,
  output logic [DATA_WIDTH-1:0] o_idu_rs2_data,
  output logic [DATA_WIDTH-1:0] o_idu_jmp_or_reg_data
);

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3,
    ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7,
    ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_EQ = 5'd10,  ALU_NE = 5'd11,
    ALU_LT = 5'd12,  ALU_GE = 5'd13,  ALU_LTU = 5'd14, ALU_GEU = 5'd15
  } alu_e;

  typedef enum logic [1:0] {RS1_GPR = 2'd0, RS1_PC = 2'd1, RS1_ZERO = 2'd2} rs1_sel_e;
  typedef enum logic [1:0] {RS2_GPR = 2'd0, RS2_IMM = 2'd1, RS2_FOUR = 2'd2} rs2_sel_e;
  typedef enum logic [1:0] {JMP_NONE = 2'd0, JMP_JAL = 2'd1, JMP_JALR = 2'd2, JMP_BR = 2'd3} jmp_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  assign opcode    = i_ram_inst[6:0];
  assign funct3    = i_ram_inst[14:12];
  assign funct7_b5 = i_ram_inst[30];

  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  assign imm_i = {{(DATA_WIDTH-11){i_ram_inst[31]}}, i_ram_inst[30:20]};
  assign imm_s = {{(DATA_WIDTH-11){i_ram_inst[31]}}, i_ram_inst[30:25], i_ram_inst[11:7]};
  assign imm_b = {{(DATA_WIDTH-12){i_ram_inst[31]}}, i_ram_inst[7], i_ram_inst[30:25],
                  i_ram_inst[11:8], 1'b0};
  assign imm_u = {{(DATA_WIDTH-31){i_ram_inst[31]}}, i_ram_inst[30:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-20){i_ram_inst[31]}}, i_ram_inst[19:12], i_ram_inst[20],
                  i_ram_inst[30:21], 1'b0};
  assign shamt = {{(DATA_WIDTH-5){1'b0}}, i_ram_inst[24:20]};

  // Register IDs are raw fields whatever the format; unused ones are simply ignored downstream.
  assign o_idu_gpr_rs1_id = i_ram_inst[19:15];
  assign o_idu_gpr_rs2_id = i_ram_inst[24:20];
  assign o_idu_gpr_rd_id  = i_ram_inst[11:7];

  alu_e                  alu_type;
  rs1_sel_e              rs1_sel;
  rs2_sel_e              rs2_sel;
  jmp_e                  jmp_type;
  logic                  ram_wr_en, reg_wr_en, wr_from_ram;
  logic [DATA_WIDTH-1:0] imm, jmp_target;

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    alu_type    = ALU_ADD;
    rs1_sel     = RS1_GPR;
    rs2_sel     = RS2_GPR;
    jmp_type    = JMP_NONE;
    ram_wr_en   = 1'b0;
    reg_wr_en   = 1'b0;
    wr_from_ram = 1'b0;
    imm         = imm_i;
    jmp_target  = i_ifu_pc + imm_j;
    unique case (opcode)
      OPC_LUI:   begin rs1_sel = RS1_ZERO; rs2_sel = RS2_IMM; imm = imm_u; reg_wr_en = 1'b1; end
      OPC_AUIPC: begin rs1_sel = RS1_PC;   rs2_sel = RS2_IMM; imm = imm_u; reg_wr_en = 1'b1; end
      OPC_JAL: begin
        rs1_sel = RS1_PC; rs2_sel = RS2_FOUR; jmp_type = JMP_JAL; reg_wr_en = 1'b1;
      end
      OPC_JALR: begin
        rs1_sel = RS1_PC; rs2_sel = RS2_FOUR; jmp_type = JMP_JALR; reg_wr_en = 1'b1;
        jmp_target = (i_gpr_rs1_data + imm_i) & ~DATA_WIDTH'(1);
      end
      OPC_BRANCH: begin
        jmp_target = i_ifu_pc + imm_b;
        jmp_type   = JMP_BR;
        unique case (funct3)
          3'd0: alu_type = ALU_EQ;
          3'd1: alu_type = ALU_NE;
          3'd4: alu_type = ALU_LT;
          3'd5: alu_type = ALU_GE;
          3'd6: alu_type = ALU_LTU;
          3'd7: alu_type = ALU_GEU;
          default: jmp_type = JMP_NONE;
        endcase
      end
      OPC_LOAD: begin
        rs2_sel = RS2_IMM; reg_wr_en = 1'b1; wr_from_ram = 1'b1;
      end
      OPC_STORE: begin rs2_sel = RS2_IMM; imm = imm_s; ram_wr_en = 1'b1; end
      OPC_OPIMM, OPC_OP: begin
        reg_wr_en = 1'b1;
        if (opcode == OPC_OPIMM) begin
          rs2_sel = RS2_IMM;
          if (funct3 == 3'd1 || funct3 == 3'd5) imm = shamt;
        end
        unique case (funct3)
          3'd0: alu_type = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'd1: alu_type = ALU_SLL;
          3'd2: alu_type = ALU_SLT;
          3'd3: alu_type = ALU_SLTU;
          3'd4: alu_type = ALU_XOR;
          3'd5: alu_type = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'd6: alu_type = ALU_OR;
          default: alu_type = ALU_AND;
        endcase
      end
      default: ;
    endcase
  end

  assign o_idu_ctr_alu_type   = alu_type;
  assign o_idu_ctr_alu_rs1    = rs1_sel;
  assign o_idu_ctr_alu_rs2    = rs2_sel;
  assign o_idu_ctr_jmp_type   = jmp_type;
  assign o_idu_ctr_ram_wr_en  = ram_wr_en;
  assign o_idu_ctr_ram_byt    = funct3;
  assign o_idu_ctr_reg_wr_en  = reg_wr_en;
  assign o_idu_ctr_reg_wr_src = {1'b0, wr_from_ram};

  always_comb begin
    o_idu_rs1_data = i_gpr_rs1_data;
    unique case (rs1_sel)
      RS1_PC:   o_idu_rs1_data = i_ifu_pc;
      RS1_ZERO: o_idu_rs1_data = '0;
      default:  o_idu_rs1_data = i_gpr_rs1_data;
    endcase
  end

  always_comb begin
    o_idu_rs2_data = i_gpr_rs2_data;
    unique case (rs2_sel)
      RS2_IMM:  o_idu_rs2_data = imm;
      RS2_FOUR: o_idu_rs2_data = DATA_WIDTH'(4);
      default:  o_idu_rs2_data = i_gpr_rs2_data;
    endcase
  end

  assign o_idu_jmp_or_reg_data = (jmp_type == JMP_NONE) ? i_gpr_rs2_data : jmp_target;

  logic valid_d, valid_q;
  assign valid_d = i_sys_ready;

  // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  assign o_sys_valid = valid_q;

endmodule

// File: tb/tb_idu_core.sv
// Directed self-checking bench for idu_core: handshake timing and per-opcode decode vectors.
module tb_idu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        valid;
  logic [31:0] inst;
  logic [4:0]  alu_type;
  logic [1:0]  alu_rs1, alu_rs2, jmp_type, wr_src;
  logic        ram_wr_en, reg_wr_en;
  logic [2:0]  ram_byt;
  logic [31:0] gpr_rs1, gpr_rs2, pc;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic [31:0] rs1_data, rs2_data, jr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idu_core #(.DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_sys_ready(ready), .o_sys_valid(valid),
    .i_ram_inst(inst),
    .o_idu_ctr_alu_type(alu_type), .o_idu_ctr_alu_rs1(alu_rs1), .o_idu_ctr_alu_rs2(alu_rs2),
    .o_idu_ctr_jmp_type(jmp_type), .o_idu_ctr_ram_wr_en(ram_wr_en), .o_idu_ctr_ram_byt(ram_byt),
    .o_idu_ctr_reg_wr_en(reg_wr_en), .o_idu_ctr_reg_wr_src(wr_src),
    .i_gpr_rs1_data(gpr_rs1), .i_gpr_rs2_data(gpr_rs2),
    .o_idu_gpr_rs1_id(rs1_id), .o_idu_gpr_rs2_id(rs2_id), .o_idu_gpr_rd_id(rd_id),
    .i_ifu_pc(pc), .o_idu_rs1_data(rs1_data), .o_idu_rs2_data(rs2_data),
    .o_idu_jmp_or_reg_data(jr_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] i);
    inst = i;
    #1;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; inst = 32'h0000_0013;
    gpr_rs1 = 32'd1; gpr_rs2 = 32'd2; pc = 32'h8000_0000;

    // Handshake
    #12;
    check("reset_valid", {31'b0, valid}, 32'd0);
    @(negedge clk); rst = 1'b0; ready = 1'b1;
    #1;
    check("valid_lags_ready", {31'b0, valid}, 32'd0);
    @(posedge clk); #1;
    check("valid_after_ready", {31'b0, valid}, 32'd1);
    @(negedge clk); ready = 1'b0;
    @(posedge clk); #1;
    check("valid_after_drop", {31'b0, valid}, 32'd0);
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1;
    check("valid_reasserted", {31'b0, valid}, 32'd1);
    #2 rst = 1'b1; #1;
    check("valid_async_clear", {31'b0, valid}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // LUI / AUIPC
    apply(32'h0000_a0b7);
    check("lui_rd", rd_id, 32'd1);
    check("lui_rs1", rs1_data, 32'd0);
    check("lui_rs2", rs2_data, 32'h0000_a000);
    check("lui_wr", reg_wr_en, 32'd1);
    apply(32'h0000_a097);
    check("auipc_rs1", rs1_data, 32'h8000_0000);
    check("auipc_rs2", rs2_data, 32'h0000_a000);

    // JAL / JALR
    apply(32'h00a0_00ef);
    check("jal_type", jmp_type, 32'd1);
    check("jal_rs1", rs1_data, 32'h8000_0000);
    check("jal_rs2", rs2_data, 32'd4);
    check("jal_target", jr_data, 32'h8000_000a);
    check("jal_wr", reg_wr_en, 32'd1);
    apply(32'h00a1_00e7);
    check("jalr_rs1_id", rs1_id, 32'd2);
    check("jalr_type", jmp_type, 32'd2);
    check("jalr_target", jr_data, 32'h0000_000a);

    // Branches
    apply(32'h0020_8563);
    check("beq_rs1_id", rs1_id, 32'd1);
    check("beq_rs2_id", rs2_id, 32'd2);
    check("beq_alu", alu_type, 32'd10);
    check("beq_op1", rs1_data, 32'd1);
    check("beq_op2", rs2_data, 32'd2);
    check("beq_type", jmp_type, 32'd3);
    check("beq_target", jr_data, 32'h8000_000a);
    check("beq_wr", reg_wr_en, 32'd0);
    apply(32'h0020_a563);
    check("bad_br_type", jmp_type, 32'd0);
    check("bad_br_alu", alu_type, 32'd0);
    check("bad_br_data", jr_data, 32'd2);

    // Load / store
    apply(32'h00a1_0083);
    check("lb_rs2", rs2_data, 32'd10);
    check("lb_byt", ram_byt, 32'd0);
    check("lb_src", wr_src, 32'd1);
    check("lb_wr", reg_wr_en, 32'd1);
    apply(32'h0011_0023);
    check("sb_ram_wr", ram_wr_en, 32'd1);
    check("sb_rs1_id", rs1_id, 32'd2);
    check("sb_rs2_id", rs2_id, 32'd1);
    check("sb_rs2", rs2_data, 32'd0);
    check("sb_data", jr_data, 32'd2);
    check("sb_reg_wr", reg_wr_en, 32'd0);

    // ALU ops
    apply(32'h00a1_0093);
    check("addi_alu", alu_type, 32'd0);
    check("addi_rs2", rs2_data, 32'd10);
    apply(32'h0031_00b3);
    check("add_alu", alu_type, 32'd0);
    check("add_rs2_id", rs2_id, 32'd3);
    check("add_rs2", rs2_data, 32'd2);
    apply(32'h4031_00b3);
    check("sub_alu", alu_type, 32'd1);
    apply(32'h4031_5093);
    check("srai_alu", alu_type, 32'd7);
    check("srai_shamt", rs2_data, 32'd3);

    // FENCE / ECALL / EBREAK act as no-ops
    apply(32'h0ff0_000f);
    check("fence_en", {jmp_type, ram_wr_en, reg_wr_en}, 32'd0);
    check("fence_sel", {alu_type, alu_rs1, alu_rs2}, 32'd0);
    apply(32'h0000_0073);
    check("ecall_en", {jmp_type, ram_wr_en, reg_wr_en}, 32'd0);
    check("ecall_op2", rs2_data, 32'd2);
    apply(32'h0010_0073);
    check("ebreak_en", {jmp_type, ram_wr_en, reg_wr_en}, 32'd0);
    check("ebreak_alu", alu_type, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idu_core.md
Name: idu_core

Overview:
- RV32I instruction decode stage of the single-issue core; sits between the IFU/instruction RAM and the EXU/LSU/WBU.
- Decodes the 32-bit instruction combinationally into ALU, jump, RAM and register-writeback controls, GPR read/write indices and operand data.
- Also produces the jump target.
- A one-register valid/ready handshake toward the system controller is the only sequential logic.

Parameters:
- DATA_WIDTH, 32, datapath width (PC, register data, immediates).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock, asynchronous, active-high.
- i_sys_ready  in  1  downstream ready.
- o_sys_valid  out  1  decode result valid.
- i_ram_inst  in  32  fetched instruction.
- o_idu_ctr_alu_type  out  5  ALU operation.
- o_idu_ctr_alu_rs1  out  2  ALU operand-1 select.
- o_idu_ctr_alu_rs2  out  2  ALU operand-2 select.
- o_idu_ctr_jmp_type  out  2  jump class.
- o_idu_ctr_ram_wr_en  out  1  store enable.
- o_idu_ctr_ram_byt  out  3  access size/sign (funct3).
- o_idu_ctr_reg_wr_en  out  1  rd write enable.
- o_idu_ctr_reg_wr_src  out  2  writeback source.
- i_gpr_rs1_data  in  DATA_WIDTH  GPR[rs1].
- i_gpr_rs2_data  in  DATA_WIDTH  GPR[rs2].
- o_idu_gpr_rs1_id  out  5  inst[19:15].
- o_idu_gpr_rs2_id  out  5  inst[24:20].
- o_idu_gpr_rd_id  out  5  inst[11:7].
- i_ifu_pc  in  DATA_WIDTH  PC of the instruction.
- o_idu_rs1_data  out  DATA_WIDTH  ALU operand 1 after select.
- o_idu_rs2_data  out  DATA_WIDTH  ALU operand 2 after select.
- o_idu_jmp_or_reg_data  out  DATA_WIDTH  jump target, or store data.

Behaviour:
- o_sys_valid is a flop: reset value 0, async clear on i_rst; each rising i_clk it loads i_sys_ready. It therefore lags ready by 1 cycle.
- All other outputs are purely combinational from the inputs (0-cycle latency) and are unaffected by reset.
- Immediates follow the RV32I I/S/B/U/J formats, sign-extended to DATA_WIDTH.
- alu_type encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - Branch compares: EQ=10, NE=11, LT=12, GE=13, LTU=14, GEU=15.
  - OP/OP-IMM select the operation from funct3/funct7[5]; SUB only for OP; SRA for funct7[5]=1.
- alu_rs1 select: 0=i_gpr_rs1_data, 1=i_ifu_pc, 2=zero.
- alu_rs2 select: 0=i_gpr_rs2_data, 1=imm, 2=constant 4.
- jmp_type: 0=none, 1=JAL, 2=JALR, 3=branch.
- reg_wr_src: 0=ALU, 1=RAM load data.
- Per opcode:
  - LUI: rs1=zero, rs2=U-imm, ADD, reg_wr 1.
  - AUIPC: rs1=pc, rs2=U-imm, ADD, reg_wr 1.
  - JAL: rs1=pc, rs2=4, ADD, jmp 1, reg_wr 1; target = pc+J-imm.
  - JALR: rs1=pc, rs2=4, ADD, jmp 2, reg_wr 1; target = (rs1_data+I-imm) & ~1.
  - BRANCH: rs1/rs2 = GPR data, compare op from funct3, jmp 3, reg_wr 0; target = pc+B-imm. Invalid funct3 (2,3) = illegal.
  - LOAD: rs1=GPR, rs2=I-imm, ADD, reg_wr 1, wr_src 1, ram_byt=funct3.
  - STORE: rs1=GPR, rs2=S-imm, ADD, ram_wr_en 1, ram_byt=funct3, reg_wr 0; jmp_or_reg_data = i_gpr_rs2_data.
  - OP-IMM: rs2=I-imm; shifts use shamt inst[24:20].
  - OP: both operands are GPR data.
- For non-jump instructions, jmp_or_reg_data = i_gpr_rs2_data.
- FENCE, ECALL, EBREAK and any unrecognised opcode behave as a no-op:
  - reg_wr_en=0, ram_wr_en=0, jmp_type=0, alu_type=ADD, selects 0.
- Register IDs are always raw fields, regardless of instruction format.
- rd=x0 still asserts reg_wr_en; the GPR file ignores the write.

Test Plan:
- Handshake, reset, ready: i_rst=1 -> o_sys_valid=0; release reset, hold ready=1 -> valid=1 one cycle later; drop ready -> valid=0 next cycle; assert i_rst mid-run -> valid=0 immediately.
- LUI, AUIPC (pc=0x80000000, rs1_data=1, rs2_data=2 throughout):
  - 0x0000a0b7 -> rd=1, rs1_data=0, rs2_data=0x0000A000, reg_wr_en=1.
  - 0x0000a097 -> rs1_data=0x80000000, rs2_data=0x0000A000.
- JAL, JALR:
  - 0x00a000ef -> jmp_type=1, rs1_data=0x80000000, rs2_data=4, jmp_or_reg_data=0x8000000A.
  - 0x00a100e7 -> rs1_id=2, jmp_type=2, jmp_or_reg_data=0x0000000A.
- BEQ: 0x00208563 -> rs1_id=1, rs2_id=2, alu_type=EQ, operands 1 and 2, jmp_type=3, target 0x8000000A, reg_wr_en=0.
- Memory:
  - 0x00a10083 -> rs2_data=10, ram_byt=0, reg_wr_src=1, reg_wr_en=1.
  - 0x00110023 -> ram_wr_en=1, rs1_id=2, rs2_id=1, rs2_data=0, jmp_or_reg_data=2.
- ALU and system:
  - 0x00a10093 -> ADD, rs2_data=10.
  - 0x003100b3 -> ADD, rs2_id=3.
  - 0x0ff0000f, 0x00000073, 0x00100073 -> all write/jump enables 0.
